// File: rtl/special_case_mult_unit.sv
// Two-stage IEEE-754 special-operand path for the multiplier: classifies both operands,
// resolves the zero/inf/NaN outcome and delivers the bypass result word with sticky flags.
module special_case_mult_unit #(
    parameter int W   = 32,
    parameter int EW  = 8,
    parameter int SW  = 23,
    parameter bit DAZ = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] Data_A,
    input  logic [W-1:0] Data_B,
    input  logic         out_ready,
    input  logic         clr,
    output logic         in_ready,
    output logic         out_valid,
    output logic         zero_m_flag,
    output logic         inf_m_flag,
    output logic         nan_m_flag,
    output logic         special_flag,
    output logic [W-1:0] special_result,
    output logic         sticky_inf,
    output logic         sticky_nan
);

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } op_class_t;

    localparam op_class_t  CLASS_NONE = 3'b000;
    localparam logic [W-1:0] QNAN_WORD = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};

    function automatic op_class_t classify(input logic [EW-1:0] exp_f, input logic [SW-1:0] mant_f);
        op_class_t c;
        c = CLASS_NONE;
        if (exp_f == {EW{1'b1}}) begin
            if (mant_f == {SW{1'b0}}) begin
                c.inf = 1'b1;
            end else begin
                c.nan = 1'b1;
            end
        end else if (exp_f == {EW{1'b0}}) begin
            // Denormals only collapse to zero when flushing is enabled.
            if ((mant_f == {SW{1'b0}}) || DAZ) begin
                c.zero = 1'b1;
            end else begin
                c.zero = 1'b0;
            end
        end else begin
            c = CLASS_NONE;
        end
        return c;
    endfunction

    logic         en_s;
    logic         hs_s;
    logic         s1_valid_q, s1_valid_d;
    op_class_t    cls_a_q, cls_a_d;
    op_class_t    cls_b_q, cls_b_d;
    logic         sign_q, sign_d;
    logic         res_nan_s, res_inf_s, res_zero_s;
    logic         out_valid_q, out_valid_d;
    logic         zero_q, zero_d;
    logic         inf_q, inf_d;
    logic         nan_q, nan_d;
    logic         special_q, special_d;
    logic [W-1:0] result_q, result_d;
    logic         sticky_inf_q, sticky_inf_d;
    logic         sticky_nan_q, sticky_nan_d;

    assign en_s     = !out_valid_q || out_ready;
    assign hs_s     = out_valid_q && out_ready;
    assign in_ready = en_s;

    // Stage 1: capture operand classes and product sign, or a bubble when idle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        cls_a_d    = cls_a_q;
        cls_b_d    = cls_b_q;
        sign_d     = sign_q;
        if (en_s) begin
            s1_valid_d = load;
            if (load) begin
                cls_a_d = classify(Data_A[W-2 -: EW], Data_A[SW-1:0]);
                cls_b_d = classify(Data_B[W-2 -: EW], Data_B[SW-1:0]);
                sign_d  = Data_A[W-1] ^ Data_B[W-1];
            end else begin
                cls_a_d = CLASS_NONE;
                cls_b_d = CLASS_NONE;
                sign_d  = 1'b0;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Outcome priority: NaN (including 0 x inf) beats inf beats zero.
    always_comb begin
        res_nan_s  = s1_valid_q && (cls_a_q.nan || cls_b_q.nan ||
                                    (cls_a_q.zero && cls_b_q.inf) ||
                                    (cls_a_q.inf && cls_b_q.zero));
        res_inf_s  = s1_valid_q && !res_nan_s && (cls_a_q.inf || cls_b_q.inf);
        res_zero_s = s1_valid_q && !res_nan_s && !res_inf_s && (cls_a_q.zero || cls_b_q.zero);
    end

    // Stage 2: build the result word and flags; hold everything while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        inf_d       = inf_q;
        nan_d       = nan_q;
        special_d   = special_q;
        result_d    = result_q;
        if (en_s) begin
            out_valid_d = s1_valid_q;
            zero_d      = res_zero_s;
            inf_d       = res_inf_s;
            nan_d       = res_nan_s;
            special_d   = res_zero_s || res_inf_s || res_nan_s;
            case ({res_nan_s, res_inf_s, res_zero_s})
                3'b100:  result_d = QNAN_WORD;
                3'b010:  result_d = {sign_q, {EW{1'b1}}, {SW{1'b0}}};
                3'b001:  result_d = {sign_q, {(W-1){1'b0}}};
                default: result_d = {W{1'b0}};
            endcase
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Sticky exception flags: a delivered result sets, clr clears, set wins a tie.
    always_comb begin
        sticky_inf_d = (sticky_inf_q && !clr) || (hs_s && inf_q);
        sticky_nan_d = (sticky_nan_q && !clr) || (hs_s && nan_q);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            cls_a_q      <= CLASS_NONE;
            cls_b_q      <= CLASS_NONE;
            sign_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            zero_q       <= 1'b0;
            inf_q        <= 1'b0;
            nan_q        <= 1'b0;
            special_q    <= 1'b0;
            result_q     <= {W{1'b0}};
            sticky_inf_q <= 1'b0;
            sticky_nan_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            cls_a_q      <= cls_a_d;
            cls_b_q      <= cls_b_d;
            sign_q       <= sign_d;
            out_valid_q  <= out_valid_d;
            zero_q       <= zero_d;
            inf_q        <= inf_d;
            nan_q        <= nan_d;
            special_q    <= special_d;
            result_q     <= result_d;
            sticky_inf_q <= sticky_inf_d;
            sticky_nan_q <= sticky_nan_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign zero_m_flag    = zero_q;
    assign inf_m_flag     = inf_q;
    assign nan_m_flag     = nan_q;
    assign special_flag   = special_q;
    assign special_result = result_q;
    assign sticky_inf     = sticky_inf_q;
    assign sticky_nan     = sticky_nan_q;

endmodule
